branch_redirect_unit: RTL and testbench

Consumer side of the branch comparator. It takes the comparator's taken flag together with the branch/jump context from decode and computes the target address. On a taken branch it issues a registered PC redirect to fetch with a valid/ready handshake, then flushes the younger pipeline stages for a fixed number of cycles. It sits between execute (comparator) and the fetch PC mux.

---
 rtl/branch_redirect_unit_pkg.sv | 23 ++
 rtl/branch_target_calc.sv | 28 ++
 rtl/branch_redirect_unit.sv | 141 ++++++++++++++
 tb/tb_branch_redirect_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_unit_pkg.sv
// Shared types and constants for the branch redirect unit.
// The redirect FSM state encoding and the instruction size used to form
// the link address live here so the top and any neighbours agree on them.
package branch_redirect_unit_pkg;

    // Redirect sequencing: wait for a branch, present the redirect, then flush.
    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_REDIRECT = 2'd1,
        RD_FLUSH    = 2'd2
    } redirect_state_e;

    // Byte size of one instruction; the link address is the branch PC plus this.
    localparam int INSTR_BYTES = 4;

    // JAL and JALR always transfer; conditional branches follow the comparator.
    function automatic logic is_taken(input logic is_jal,
                                      input logic is_jalr,
                                      input logic cmp_taken);
        return is_jal | is_jalr | cmp_taken;
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch/jump target computation.
// JALR adds the immediate to rs1 and clears bit 0; JAL and conditional
// branches add the immediate to the branch PC. All sums wrap at DW bits.
// A target is misaligned when either of its two low bits is set.
module branch_target_calc #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] rs1,
    input  logic          is_jalr,
    output logic [DW-1:0] target,
    output logic          misaligned
);

    logic [DW-1:0] w_base;
    logic [DW-1:0] w_sum;

    assign w_base = is_jalr ? rs1 : pc;
    assign w_sum  = w_base + imm;

    // Clear bit 0 only for JALR, then flag any residual sub-word offset.
    always_comb begin
        target     = is_jalr ? {w_sum[DW-1:1], 1'b0} : w_sum;
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: consumes the comparator result plus decode context,
// issues a registered PC redirect to fetch over a valid/ready handshake and
// then flushes younger stages for FLUSH_STAGES cycles.
// Optional build macro BRANCH_STATS_EN adds branch and taken-transfer counters.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int DW           = 32,
    parameter int FLUSH_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          br_valid_i,
    output logic          br_ready_o,
    input  logic          br_is_jal_i,
    input  logic          br_is_jalr_i,
    input  logic          cmp_zero_i,
    input  logic [DW-1:0] br_pc_i,
    input  logic [DW-1:0] br_imm_i,
    input  logic [DW-1:0] rs1_val_i,
    output logic          redirect_valid_o,
    input  logic          redirect_ready_i,
    output logic [DW-1:0] redirect_pc_o,
    output logic [DW-1:0] link_addr_o,
    output logic          flush_o,
    output logic          stall_o,
    output logic          misalign_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]   br_count_o,
    output logic [31:0]   taken_count_o
`endif
);

    localparam int CNT_W = $clog2(FLUSH_STAGES + 1);

    redirect_state_e r_state;
    redirect_state_e w_next_state;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [DW-1:0]    r_redirect_pc;
    logic [DW-1:0]    r_link_addr;
    logic             r_misalign;

    logic             w_accept;
    logic             w_taken;
    logic             w_transfer;
    logic [DW-1:0]    w_target;
    logic             w_misaligned;
    logic [DW-1:0]    w_link_addr;

    branch_target_calc #(.DW(DW)) u_target_calc (
        .pc         (br_pc_i),
        .imm        (br_imm_i),
        .rs1        (rs1_val_i),
        .is_jalr    (br_is_jalr_i),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    assign br_ready_o  = (r_state == RD_IDLE);
    assign w_accept    = br_valid_i && br_ready_o;
    assign w_taken     = is_taken(br_is_jal_i, br_is_jalr_i, cmp_zero_i);
    assign w_transfer  = w_accept && w_taken && !w_misaligned;
    assign w_link_addr = br_pc_i + DW'(INSTR_BYTES);

    assign redirect_pc_o = r_redirect_pc;
    assign link_addr_o   = r_link_addr;
    assign misalign_o    = r_misalign;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) r_state <= RD_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and handshake/flush outputs decoded from the current state.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next_state     = r_state;
        redirect_valid_o = 1'b0;
        flush_o          = 1'b0;
        stall_o          = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (w_transfer) w_next_state = RD_REDIRECT;
            end
            RD_REDIRECT: begin
                redirect_valid_o = 1'b1;
                stall_o          = 1'b1;
                if (redirect_ready_i) w_next_state = RD_FLUSH;
            end
            RD_FLUSH: begin
                flush_o = 1'b1;
                stall_o = 1'b1;
                if (r_flush_cnt == CNT_W'(1)) w_next_state = RD_IDLE;
            end
            default: w_next_state = RD_IDLE;
        endcase
    end

    // Capture target/link on acceptance, pulse misalign, run the flush counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt   <= '0;
            r_redirect_pc <= '0;
            r_link_addr   <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_taken && w_misaligned;
            if (w_accept)   r_link_addr   <= w_link_addr;
            if (w_transfer) r_redirect_pc <= w_target;
            if (r_state == RD_REDIRECT && redirect_ready_i)
                r_flush_cnt <= CNT_W'(FLUSH_STAGES);
            else if (r_state == RD_FLUSH)
                r_flush_cnt <= r_flush_cnt - CNT_W'(1);
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_taken_count;

    assign br_count_o    = r_br_count;
    assign taken_count_o = r_taken_count;

    // Free-running wrap-around counters of accepted and taken-aligned branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            if (w_accept)   r_br_count    <= r_br_count + 32'd1;
            if (w_transfer) r_taken_count <= r_taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_branch_redirect_unit;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          br_valid_i;
    logic          br_ready_o;
    logic          br_is_jal_i;
    logic          br_is_jalr_i;
    logic          cmp_zero_i;
    logic [DW-1:0] br_pc_i;
    logic [DW-1:0] br_imm_i;
    logic [DW-1:0] rs1_val_i;
    logic          redirect_valid_o;
    logic          redirect_ready_i;
    logic [DW-1:0] redirect_pc_o;
    logic [DW-1:0] link_addr_o;
    logic          flush_o;
    logic          stall_o;
    logic          misalign_o;
`ifdef BRANCH_STATS_EN
    logic [31:0]   br_count_o;
    logic [31:0]   taken_count_o;
`endif

    int total = 0;
    int bad   = 0;

    branch_redirect_unit #(.DW(DW), .FLUSH_STAGES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .br_valid_i       (br_valid_i),
        .br_ready_o       (br_ready_o),
        .br_is_jal_i      (br_is_jal_i),
        .br_is_jalr_i     (br_is_jalr_i),
        .cmp_zero_i       (cmp_zero_i),
        .br_pc_i          (br_pc_i),
        .br_imm_i         (br_imm_i),
        .rs1_val_i        (rs1_val_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .link_addr_o      (link_addr_o),
        .flush_o          (flush_o),
        .stall_o          (stall_o),
        .misalign_o       (misalign_o)
`ifdef BRANCH_STATS_EN
        ,
        .br_count_o       (br_count_o),
        .taken_count_o    (taken_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one context for a single cycle; it is accepted at the edge
    // because every call is made while the unit is idle.
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic jal,
                         input logic jalr, input logic cmp);
        br_valid_i   = 1'b1;
        br_pc_i      = pc;
        br_imm_i     = imm;
        rs1_val_i    = rs1;
        br_is_jal_i  = jal;
        br_is_jalr_i = jalr;
        cmp_zero_i   = cmp;
        step();
        br_valid_i   = 1'b0;
        br_is_jal_i  = 1'b0;
        br_is_jalr_i = 1'b0;
        cmp_zero_i   = 1'b0;
    endtask

    // Bounded wait for the unit to report ready again.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (!br_ready_o && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(br_ready_o), 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        br_valid_i       = 1'b0;
        br_is_jal_i      = 1'b0;
        br_is_jalr_i     = 1'b0;
        cmp_zero_i       = 1'b0;
        br_pc_i          = '0;
        br_imm_i         = '0;
        rs1_val_i        = '0;
        redirect_ready_i = 1'b1;

        // Reset held three cycles, then released.
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_ready",    32'(br_ready_o),       32'd1);
        check("rst_valid",    32'(redirect_valid_o), 32'd0);
        check("rst_flush",    32'(flush_o),          32'd0);
        check("rst_stall",    32'(stall_o),          32'd0);
        check("rst_misalign", 32'(misalign_o),       32'd0);
        check("rst_rpc",      redirect_pc_o,         32'h0);
        check("rst_link",     link_addr_o,           32'h0);

        // BEQ taken: 0x100 + 0x20, fetch always ready.
        issue(32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
        check("beq_valid",   32'(redirect_valid_o), 32'd1);
        check("beq_rpc",     redirect_pc_o,         32'h120);
        check("beq_link",    link_addr_o,           32'h104);
        check("beq_stall",   32'(stall_o),          32'd1);
        check("beq_ready0",  32'(br_ready_o),       32'd0);
        step();
        check("beq_valid_drop", 32'(redirect_valid_o), 32'd0);
        check("beq_flush1",  32'(flush_o),          32'd1);
        step();
        check("beq_flush2",  32'(flush_o),          32'd1);
        step();
        check("beq_flush_end", 32'(flush_o),        32'd0);
        check("beq_ready_back", 32'(br_ready_o),    32'd1);
        check("beq_stall_end", 32'(stall_o),        32'd0);

        // BNE not taken: only link changes.
        issue(32'h200, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
        check("bne_ready",   32'(br_ready_o),       32'd1);
        check("bne_valid",   32'(redirect_valid_o), 32'd0);
        check("bne_flush",   32'(flush_o),          32'd0);
        check("bne_link",    link_addr_o,           32'h204);
        check("bne_rpc_hold", redirect_pc_o,        32'h120);
        step();
        check("bne_ready2",  32'(br_ready_o),       32'd1);

        // JALR aligned: (0x1003 + 0x5) & ~1 = 0x1008; fetch stalls 3 cycles.
        // A held not-taken context must be ignored until the unit is idle.
        redirect_ready_i = 1'b0;
        issue(32'h300, 32'h5, 32'h1003, 1'b0, 1'b1, 1'b0);
        br_valid_i = 1'b1;
        br_pc_i    = 32'h500;
        check("jalr_misalign", 32'(misalign_o), 32'd0);
        check("jalr_link",   link_addr_o,       32'h304);
        for (int i = 0; i < 3; i++) begin
            check("jalr_hold_valid", 32'(redirect_valid_o), 32'd1);
            check("jalr_hold_rpc",   redirect_pc_o,         32'h1008);
            check("jalr_hold_stall", 32'(stall_o),          32'd1);
            check("jalr_ignore_link", link_addr_o,          32'h304);
            step();
        end
        check("jalr_hold_valid3", 32'(redirect_valid_o), 32'd1);
        redirect_ready_i = 1'b1;
        step();
        check("jalr_flush1", 32'(flush_o),      32'd1);
        check("jalr_fl_link", link_addr_o,      32'h304);
        step();
        check("jalr_flush2", 32'(flush_o),      32'd1);
        step();
        check("b2b_idle_ready", 32'(br_ready_o), 32'd1);
        check("b2b_link_pre",   link_addr_o,     32'h304);
        step();
        br_valid_i = 1'b0;
        check("b2b_link_post",  link_addr_o,     32'h504);
        check("b2b_no_redirect", 32'(redirect_valid_o), 32'd0);

        // JALR with bit 1 left set: (0x1003 + 0x4) & ~1 = 0x1006 is misaligned.
        issue(32'h300, 32'h4, 32'h1003, 1'b0, 1'b1, 1'b0);
        check("jalr_mis_pulse", 32'(misalign_o),       32'd1);
        check("jalr_mis_noval", 32'(redirect_valid_o), 32'd0);
        step();
        check("jalr_mis_clear", 32'(misalign_o),       32'd0);

        // JAL misaligned: 0x100 + 0x6 = 0x106, taken even with cmp_zero=0.
        issue(32'h100, 32'h6, 32'h0, 1'b1, 1'b0, 1'b0);
        check("jal_mis_pulse", 32'(misalign_o),        32'd1);
        check("jal_mis_noval", 32'(redirect_valid_o),  32'd0);
        check("jal_mis_ready", 32'(br_ready_o),        32'd1);
        check("jal_mis_rpc",   redirect_pc_o,          32'h1008);
        step();
        check("jal_mis_clear", 32'(misalign_o),        32'd0);
        check("jal_mis_noval2", 32'(redirect_valid_o), 32'd0);

        // JAL and JALR both set: JALR rule, 0x2000 + 0x10 (not 0x400 + 0x10).
        issue(32'h400, 32'h10, 32'h2000, 1'b1, 1'b1, 1'b0);
        check("both_rpc", redirect_pc_o, 32'h2010);
        wait_idle("both_idle");

        // Wrap-around: 0xFFFFFFF0 + 0x20 = 0x10, link 0xFFFFFFF4.
        issue(32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
        check("wrap_rpc",  redirect_pc_o, 32'h10);
        check("wrap_link", link_addr_o,   32'hFFFF_FFF4);
        wait_idle("wrap_idle");

        // Reset during the first flush cycle aborts the sequence.
        issue(32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        check("rstfl_flush_on", 32'(flush_o), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstfl_flush",  32'(flush_o),          32'd0);
        check("rstfl_ready",  32'(br_ready_o),       32'd1);
        check("rstfl_stall",  32'(stall_o),          32'd0);
        check("rstfl_valid",  32'(redirect_valid_o), 32'd0);
        check("rstfl_rpc",    redirect_pc_o,         32'h0);

`ifdef BRANCH_STATS_EN
        // Three taken-aligned and two not-taken since the last reset.
        check("stat_br_zero",    br_count_o,    32'd0);
        check("stat_taken_zero", taken_count_o, 32'd0);
        issue(32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
        wait_idle("stat_idle1");
        issue(32'h200, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(32'h300, 32'h0, 32'h40, 1'b0, 1'b1, 1'b0);
        wait_idle("stat_idle2");
        issue(32'h400, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(32'h500, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
        wait_idle("stat_idle3");
        check("stat_br",    br_count_o,    32'd5);
        check("stat_taken", taken_count_o, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
